// File: rtl/encoder_pkg.sv
// Shared definitions for the priority encoder family:
// FSM state codes and the index-width helper.
package encoder_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// Combinational N-bit priority encoder.
// Highest set index wins; all-zero gives idx 0, any 0.
module priority_encoder_n
  import encoder_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_grant_arbiter.sv
// Registered sticky-request arbiter with fixed or
// round-robin priority and a valid/ack grant handshake.
module priority_grant_arbiter
  import encoder_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int ROUND_ROBIN = 0,
  localparam int IDX_W       = idx_width(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             grant_ack,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [WIDTH-1:0] grant_onehot,
  output logic [WIDTH-1:0] pending
);

  logic [0:0]       r_state;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_onehot;
  logic [WIDTH-1:0] r_pending;

  logic             w_accept;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_elig;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_any;
  logic [WIDTH-1:0] w_win_onehot;

  assign w_accept = (r_state == ST_GRANT) && grant_ack;
  assign w_clr    = w_accept ? r_onehot : '0;
  assign w_elig   = r_pending & mask;

  assign w_win_onehot =
    {{(WIDTH-1){1'b0}}, 1'b1} << w_win_idx;

  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      logic [IDX_W-1:0] r_ptr;
      logic [WIDTH-1:0] w_low;
      logic [IDX_W-1:0] w_lo_idx;
      logic [IDX_W-1:0] w_full_idx;
      logic             w_lo_any;
      logic             w_full_any;

      // Eligible lines strictly below the last winner.
      always_comb begin
        w_low = '0;
        for (int i = 0; i < WIDTH; i++) begin
          w_low[i] = w_elig[i] && (IDX_W'(i) < r_ptr);
        end
      end

      priority_encoder_n #(.WIDTH(WIDTH)) u_enc_lo (
        .vec (w_low),
        .idx (w_lo_idx),
        .any (w_lo_any)
      );

      priority_encoder_n #(.WIDTH(WIDTH)) u_enc_full (
        .vec (w_elig),
        .idx (w_full_idx),
        .any (w_full_any)
      );

      // Below-pointer hit first, else wrap to the top.
      assign w_win_idx = w_lo_any ? w_lo_idx
                                  : w_full_idx;
      assign w_win_any = w_full_any;

      // Pointer remembers the last accepted grant.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_ptr <= '0;
        end else if (w_accept) begin
          r_ptr <= r_idx;
        end
      end
    end else begin : g_fixed
      priority_encoder_n #(.WIDTH(WIDTH)) u_enc (
        .vec (w_elig),
        .idx (w_win_idx),
        .any (w_win_any)
      );
    end
  endgenerate

  // Sticky pending bits; a new request beats a clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | req_in;
    end
  end

  // Grant FSM: latch a winner, hold it until acked.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_idx    <= w_win_idx;
            r_onehot <= w_win_onehot;
            r_valid  <= 1'b1;
            r_state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (grant_ack) begin
            r_valid  <= 1'b0;
            r_onehot <= '0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_valid  = r_valid;
  assign grant_idx    = r_idx;
  assign grant_onehot = r_onehot;
  assign pending      = r_pending;

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// Bench for priority_grant_arbiter: fixed and
// round-robin instances, table vectors plus random.
module tb_priority_grant_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] msk;
  logic       ack;

  logic       f_valid, r_valid;
  logic [2:0] f_idx, r_idx;
  logic [7:0] f_oh, r_oh;
  logic [7:0] f_pend, r_pend;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_pend[2];
  logic       m_valid[2];
  int         m_idx[2];
  int         m_ptr[2];

  priority_grant_arbiter #(
    .WIDTH(8), .ROUND_ROBIN(0)
  ) u_fix (
    .CLK(clk), .RESET(rst), .req_in(req), .mask(msk),
    .grant_ack(ack), .grant_valid(f_valid),
    .grant_idx(f_idx), .grant_onehot(f_oh),
    .pending(f_pend)
  );

  priority_grant_arbiter #(
    .WIDTH(8), .ROUND_ROBIN(1)
  ) u_rr (
    .CLK(clk), .RESET(rst), .req_in(req), .mask(msk),
    .grant_ack(ack), .grant_valid(r_valid),
    .grant_idx(r_idx), .grant_onehot(r_oh),
    .pending(r_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] msk;
    logic       ack;
    logic       fv;
    int         fi;
    logic [7:0] fp;
    logic       rv;
    int         ri;
    logic [7:0] rp;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [7:0] oh(input logic v,
                                    input int i);
    logic [7:0] one;
    one = 8'd1;
    return v ? (one << i) : 8'h00;
  endfunction

  // Search order ptr-1 .. 0, then 7 .. ptr.
  function automatic int pick(input logic [7:0] e,
                              input int p);
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = (p - k + 8) % 8;
      if (e[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_step(input int md);
    logic [7:0] e;
    logic       acc;
    if (rst) begin
      m_pend[md]  = 8'h00;
      m_valid[md] = 1'b0;
      m_idx[md]   = 0;
      m_ptr[md]   = 0;
      return;
    end
    acc = m_valid[md] && ack;
    e   = m_pend[md] & msk;
    m_pend[md] = (m_pend[md] & ~oh(acc, m_idx[md])) | req;
    if (!m_valid[md]) begin
      if (e != 8'h00) begin
        m_idx[md]   = pick(e, m_ptr[md]);
        m_valid[md] = 1'b1;
      end
    end else if (ack) begin
      m_valid[md] = 1'b0;
      if (md == 1) m_ptr[md] = m_idx[md];
    end
  endtask

  task automatic apply(input logic r, input logic [7:0] q,
                       input logic [7:0] m, input logic a);
    rst = r;
    req = q;
    msk = m;
    ack = a;
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string t);
    chk({t, "_f_valid"}, f_valid, m_valid[0]);
    chk({t, "_f_idx"}, f_idx, m_idx[0]);
    chk({t, "_f_oh"}, f_oh, oh(m_valid[0], m_idx[0]));
    chk({t, "_f_pend"}, f_pend, m_pend[0]);
    chk({t, "_r_valid"}, r_valid, m_valid[1]);
    chk({t, "_r_idx"}, r_idx, m_idx[1]);
    chk({t, "_r_oh"}, r_oh, oh(m_valid[1], m_idx[1]));
    chk({t, "_r_pend"}, r_pend, m_pend[1]);
  endtask

  initial begin
    logic [7:0] hold_f_oh, hold_r_oh, saved_f, saved_r;
    int         hold_f_idx, hold_r_idx;

    tbl[0]  = '{1'b1, 8'hFF, 8'hFF, 1'b0,
                1'b0, 0, 8'h00, 1'b0, 0, 8'h00};
    tbl[1]  = '{1'b1, 8'hFF, 8'hFF, 1'b0,
                1'b0, 0, 8'h00, 1'b0, 0, 8'h00};
    tbl[2]  = '{1'b0, 8'h25, 8'hFF, 1'b0,
                1'b0, 0, 8'h25, 1'b0, 0, 8'h25};
    tbl[3]  = '{1'b0, 8'h00, 8'hFF, 1'b0,
                1'b1, 5, 8'h25, 1'b1, 5, 8'h25};
    tbl[4]  = '{1'b0, 8'h00, 8'hFF, 1'b1,
                1'b0, 5, 8'h05, 1'b0, 5, 8'h05};
    tbl[5]  = '{1'b0, 8'h00, 8'hFF, 1'b0,
                1'b1, 2, 8'h05, 1'b1, 2, 8'h05};
    tbl[6]  = '{1'b0, 8'h00, 8'hFF, 1'b1,
                1'b0, 2, 8'h01, 1'b0, 2, 8'h01};
    tbl[7]  = '{1'b0, 8'h00, 8'hFF, 1'b0,
                1'b1, 0, 8'h01, 1'b1, 0, 8'h01};
    tbl[8]  = '{1'b0, 8'h00, 8'hFF, 1'b1,
                1'b0, 0, 8'h00, 1'b0, 0, 8'h00};
    tbl[9]  = '{1'b0, 8'h81, 8'h7F, 1'b0,
                1'b0, 0, 8'h81, 1'b0, 0, 8'h81};
    tbl[10] = '{1'b0, 8'h00, 8'h7F, 1'b0,
                1'b1, 0, 8'h81, 1'b1, 0, 8'h81};
    tbl[11] = '{1'b0, 8'h00, 8'h7F, 1'b1,
                1'b0, 0, 8'h80, 1'b0, 0, 8'h80};
    tbl[12] = '{1'b0, 8'h00, 8'h7F, 1'b0,
                1'b0, 0, 8'h80, 1'b0, 0, 8'h80};
    tbl[13] = '{1'b0, 8'h00, 8'hFF, 1'b0,
                1'b1, 7, 8'h80, 1'b1, 7, 8'h80};
    tbl[14] = '{1'b0, 8'h00, 8'hFF, 1'b1,
                1'b0, 7, 8'h00, 1'b0, 7, 8'h00};
    tbl[15] = '{1'b1, 8'h00, 8'hFF, 1'b0,
                1'b0, 0, 8'h00, 1'b0, 0, 8'h00};
    tbl[16] = '{1'b0, 8'h09, 8'hFF, 1'b1,
                1'b0, 0, 8'h09, 1'b0, 0, 8'h09};
    tbl[17] = '{1'b0, 8'h09, 8'hFF, 1'b1,
                1'b1, 3, 8'h09, 1'b1, 3, 8'h09};
    tbl[18] = '{1'b0, 8'h09, 8'hFF, 1'b1,
                1'b0, 3, 8'h09, 1'b0, 3, 8'h09};
    tbl[19] = '{1'b0, 8'h09, 8'hFF, 1'b1,
                1'b1, 3, 8'h09, 1'b1, 0, 8'h09};
    tbl[20] = '{1'b0, 8'h09, 8'hFF, 1'b1,
                1'b0, 3, 8'h09, 1'b0, 0, 8'h09};
    tbl[21] = '{1'b0, 8'h09, 8'hFF, 1'b1,
                1'b1, 3, 8'h09, 1'b1, 3, 8'h09};
    tbl[22] = '{1'b0, 8'h09, 8'hFF, 1'b1,
                1'b0, 3, 8'h09, 1'b0, 3, 8'h09};
    tbl[23] = '{1'b0, 8'h09, 8'hFF, 1'b1,
                1'b1, 3, 8'h09, 1'b1, 0, 8'h09};
    tbl[24] = '{1'b0, 8'h00, 8'hFF, 1'b1,
                1'b0, 3, 8'h01, 1'b0, 0, 8'h08};

    for (int md = 0; md < 2; md++) begin
      m_pend[md]  = 8'h00;
      m_valid[md] = 1'b0;
      m_idx[md]   = 0;
      m_ptr[md]   = 0;
    end
    rst = 1'b1;
    req = 8'hFF;
    msk = 8'hFF;
    ack = 1'b0;
    @(negedge clk);

    // Directed table: reset, fixed order, masking, RR vs fixed.
    for (int i = 0; i < 25; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      apply(tbl[i].rst, tbl[i].req, tbl[i].msk, tbl[i].ack);
      chk({t, "_f_valid"}, f_valid, tbl[i].fv);
      chk({t, "_f_idx"}, f_idx, tbl[i].fi);
      chk({t, "_f_oh"}, f_oh, oh(tbl[i].fv, tbl[i].fi));
      chk({t, "_f_pend"}, f_pend, tbl[i].fp);
      chk({t, "_r_valid"}, r_valid, tbl[i].rv);
      chk({t, "_r_idx"}, r_idx, tbl[i].ri);
      chk({t, "_r_oh"}, r_oh, oh(tbl[i].rv, tbl[i].ri));
      chk({t, "_r_pend"}, r_pend, tbl[i].rp);
    end

    // Grant stays frozen while ack is low.
    apply(1'b0, 8'h00, 8'hFF, 1'b0);
    check_model("stab_grant");
    chk("stab_f_first", f_idx, 0);
    chk("stab_r_first", r_idx, 3);
    hold_f_idx = m_idx[0];
    hold_r_idx = m_idx[1];
    hold_f_oh  = oh(1'b1, hold_f_idx);
    hold_r_oh  = oh(1'b1, hold_r_idx);
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 8'($urandom), 8'($urandom), 1'b0);
      check_model("stab_hold");
      chk("hold_f_idx", f_idx, hold_f_idx);
      chk("hold_f_oh", f_oh, hold_f_oh);
      chk("hold_r_idx", r_idx, hold_r_idx);
      chk("hold_r_oh", r_oh, hold_r_oh);
    end

    // Accept, then ack while idle must change nothing.
    apply(1'b0, 8'h00, 8'h00, 1'b1);
    check_model("idle_acc");
    saved_f = m_pend[0];
    saved_r = m_pend[1];
    apply(1'b0, 8'h00, 8'h00, 1'b1);
    check_model("idle_ack");
    chk("idle_ack_f_pend", f_pend, saved_f);
    chk("idle_ack_r_pend", r_pend, saved_r);
    chk("idle_ack_f_valid", f_valid, 1'b0);
    chk("idle_ack_r_valid", r_valid, 1'b0);

    // Reset during an acked grant restores the pointer.
    apply(1'b1, 8'h00, 8'hFF, 1'b0);
    apply(1'b0, 8'h09, 8'hFF, 1'b0);
    apply(1'b0, 8'h00, 8'hFF, 1'b0);
    check_model("mid_g1");
    apply(1'b0, 8'h00, 8'hFF, 1'b1);
    apply(1'b0, 8'h09, 8'hFF, 1'b0);
    check_model("mid_g2");
    chk("mid_r_second", r_idx, 0);
    apply(1'b1, 8'h09, 8'hFF, 1'b1);
    check_model("mid_rst");
    chk("mid_rst_r_valid", r_valid, 1'b0);
    chk("mid_rst_r_pend", r_pend, 8'h00);
    chk("mid_rst_r_idx", r_idx, 0);
    apply(1'b0, 8'h09, 8'hFF, 1'b0);
    apply(1'b0, 8'h00, 8'hFF, 1'b0);
    check_model("mid_post");
    chk("mid_post_r_idx", r_idx, 3);
    chk("mid_post_r_valid", r_valid, 1'b1);

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      logic       rr;
      logic [7:0] qq, mm;
      logic       aa;
      rr = ($urandom_range(0, 49) == 0);
      qq = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                       : 8'h00;
      mm = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                       : 8'hFF;
      aa = 1'($urandom_range(0, 1));
      apply(rr, qq, mm, aa);
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/priority_grant_arbiter.md
# priority_grant_arbiter

Parametrised, registered priority arbiter that grows the team's fixed-width combinational priority encoders into a sequential block. It captures sticky request bits, masks them, and picks a winner with either fixed priority (highest index wins) or round-robin priority. It presents the winner through a valid/ack handshake. It sits in front of interrupt/exception cause selection and any multi-requester shared resource in the core.

## Interface
- `WIDTH`, 16: number of request lines; legal range 2..64, any value (need not be a power of two).
- `IDX_W`, derived = max(1, $clog2(WIDTH)): index width; not overridden by instantiators.
- `ROUND_ROBIN`, 0: 0 = fixed priority (highest index wins), 1 = rotating priority.
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `req_in` in WIDTH: request pulses; each set bit sets the matching pending bit.
- `mask` in WIDTH: 1 = line eligible for grant; 0 = held pending but ignored.
- `grant_ack` in 1: consumer accepts the current grant.
- `grant_valid` out 1: a grant is presented.
- `grant_idx` out IDX_W: index of the granted line.
- `grant_onehot` out WIDTH: one-hot of `grant_idx` while valid, else 0.
- `pending` out WIDTH: current sticky pending register.

## Operation
- Pending update every cycle: `pending <= (pending & ~clr) | req_in`, where `clr` = `grant_onehot` when `grant_valid & grant_ack`, else 0. Set wins over clear on the same bit, so a request is never lost.
- Eligible vector `elig = pending & mask`, taken from the registered `pending`.
- Fixed mode: the winner is the highest set index of `elig`.
- Round-robin mode: pointer `ptr` holds the last granted index. Search order is ptr-1 down to 0, then WIDTH-1 down to ptr.
  - Implementation: if `elig & lowmask(ptr)` (bits < ptr) is nonzero, take its highest set index; else take the highest set index of `elig`.
  - `ptr` updates to `grant_idx` on each accepted grant.
- FSM, two states:
  - IDLE: if `elig != 0`, register the winner into `grant_idx`/`grant_onehot`, set `grant_valid`, and go to GRANT. Otherwise stay.
  - GRANT: outputs are frozen. On `grant_ack`, clear `grant_valid`/`grant_onehot`, clear that pending bit, update `ptr` (RR mode), and go to IDLE. Otherwise stay.
- Mask or `req_in` changes during GRANT never revoke or alter the presented grant.
- `grant_ack` while in IDLE is ignored and has no side effects.
- Reset values: `grant_valid` 0, `grant_idx` 0, `grant_onehot` 0, `pending` 0, `ptr` 0, state IDLE.
  - With `ptr` = 0, the first round-robin search order equals the fixed order.
- Reset has priority over every other input, including an in-flight grant and a simultaneous `req_in`.

## Timing
- Latency: `req_in` asserted in cycle 0 with the block IDLE → `pending` set at edge 1 → `grant_valid` high from edge 2.
- Grant holds for ≥1 cycle and is accepted in the first cycle where `grant_valid & grant_ack`.
- After an accepted ack at edge k, the state is IDLE at k; the next grant is visible at edge k+1 at the earliest.
  - Peak throughput is one grant per 2 cycles.
- `grant_idx` holds its last value after ack (not cleared); consumers qualify it with `grant_valid`.
- No combinational path from any input to any output.

## Structure
- Shared package `encoder_pkg`:
  - FSM state localparams (`ST_IDLE`, `ST_GRANT`).
  - An `idx_width(n)` function returning max(1, clog2(n)).
- One sub-module, `priority_encoder_n`:
  - Combinational, parameter `WIDTH`, highest-set-index-wins.
  - Outputs `idx` and `any`; all-zero input yields idx 0, any 0.
  - Instantiated twice in RR mode (low-masked and full) and once in fixed mode.
- The top module holds the pending register, FSM, pointer, and output registers.

## Test plan
- Reset: drive `RESET` for 2 cycles with `req_in`=8'hFF → all outputs 0 at release; `pending`=0x00.
- Fixed order (`WIDTH`=8, mask 0xFF): `req_in`=8'h25 for 1 cycle at cycle 0, ack each grant 1 cycle after valid → `grant_idx` 5 (onehot 0x20) valid at cycle 2, then 2, then 0; `pending`=0x00 afterwards.
- Masking: `pending`=0x81, mask 0x7F → grant 0 only, `pending`=0x80 stays. Then set mask 0xFF → grant 7 two cycles later.
- Round-robin vs fixed: `req_in` held at 8'h09 with ack held high. `ROUND_ROBIN`=1 → grants 3,0,3,0. `ROUND_ROBIN`=0 → grants 3,3,3 (set-wins re-arms bit 3).
- Handshake stability: hold ack low for 5 cycles while toggling `mask` and `req_in` → `grant_idx`/`grant_onehot` unchanged. Ack pulse while `grant_valid`=0 → no state change.
- Reset mid-grant: assert `RESET` while `grant_valid`=1 and ack=1 in the same cycle → next cycle all outputs 0; `ptr` back to 0 (next RR grant from 0x09 is 3).
